pid_move_sequencer: RTL and testbench

Sequences the PID steering datapath for one move command: latches a desired heading and square count, then generates the signed heading error and its valid strobe. It drives the moving enable, aligns to the heading, ramps the forward speed up, counts line crossings, and ramps back down to a stop. It sits between the command processor and the PID block, feeding that block's moving, err_vld, error and frwrd inputs.

---
 rtl/pid_move_sequencer.sv | 157 +++++++++++++++
 tb/tb_pid_move_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pid_move_sequencer.sv
// pid_move_sequencer: runs one move command for the PID steering datapath.
// It latches a desired heading and a square count, then walks the move
// through its phases: align to the heading, ramp the forward speed up,
// cruise while counting line crossings, ramp down, and finish.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   cmd_vld/cmd_rdy      command handshake (cmd_rdy high only in IDLE)
//   cmd_hdg, cmd_sqrs    desired heading and squares to travel
//   heading, heading_rdy gyro heading and its 1-cycle sample strobe
//   cntrIR               centre line sensor (level)
//   moving, frwrd        PID enable and forward speed
//   error, err_vld       signed heading error and its valid strobe
//   done                 1-cycle pulse on move completion
module pid_move_sequencer #(
  parameter bit          FAST_SIM      = 1'b1,
  parameter logic [9:0]  RAMP_SLOW     = 10'h003,
  parameter logic [9:0]  RAMP_FAST     = 10'h020,
  parameter logic [9:0]  FRWRD_MAX     = 10'h300,
  parameter logic [11:0] SETTLE_THRESH = 12'h02C
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_vld,
  input  logic [11:0] cmd_hdg,
  input  logic [3:0]  cmd_sqrs,
  output logic        cmd_rdy,
  input  logic [11:0] heading,
  input  logic        heading_rdy,
  input  logic        cntrIR,
  output logic        moving,
  output logic [9:0]  frwrd,
  output logic [11:0] error,
  output logic        err_vld,
  output logic        done
);

  localparam int unsigned HDG_W = 12;
  localparam int unsigned SPD_W = 10;
  localparam int unsigned CNT_W = 5;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ALIGN   = 3'd1,
    RAMP_UP = 3'd2,
    CRUISE  = 3'd3,
    RAMP_DN = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t           state;
  logic [HDG_W-1:0] dsrd_hdg;
  logic [CNT_W-1:0] target;
  logic [CNT_W-1:0] line_cnt;
  logic             cntrIR_ff;

  logic [SPD_W-1:0] step;
  logic [HDG_W-1:0] err_mag;
  logic             aligned;
  logic             rise;
  logic             counting;
  logic [CNT_W-1:0] cnt_nxt;
  logic             hit;
  logic [SPD_W:0]   up_sum;
  logic [SPD_W-1:0] up_val;
  logic [SPD_W-1:0] dn_val;

  // PID-facing decodes and pass-throughs
  assign error   = HDG_W'(heading - dsrd_hdg);
  assign err_vld = heading_rdy;
  assign moving  = (state != IDLE);
  assign cmd_rdy = (state == IDLE);

  assign step = FAST_SIM ? RAMP_FAST : RAMP_SLOW;

  // Magnitude of the signed error; 12'h800 maps to itself and never aligns
  assign err_mag = error[HDG_W-1] ? HDG_W'(~error + 12'd1) : error;
  assign aligned = (err_mag < SETTLE_THRESH);

  // Line counting, including a rise seen in the current cycle
  assign rise     = cntrIR & ~cntrIR_ff;
  assign counting = (state == RAMP_UP) || (state == CRUISE);
  assign cnt_nxt  = (counting && rise && (line_cnt != 5'd31)) ?
                    CNT_W'(line_cnt + 5'd1) : line_cnt;
  assign hit      = counting && (cnt_nxt == target);

  // Ramp arithmetic; the up sum carries an extra bit so it cannot wrap
  assign up_sum = (SPD_W+1)'({1'b0, frwrd}) + (SPD_W+1)'({1'b0, step});
  assign up_val = (up_sum >= {1'b0, FRWRD_MAX}) ? FRWRD_MAX : up_sum[SPD_W-1:0];
  assign dn_val = (frwrd <= step) ? '0 : SPD_W'(frwrd - step);

  // Move sequencer FSM with registered speed and done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      frwrd     <= '0;
      dsrd_hdg  <= '0;
      target    <= '0;
      line_cnt  <= '0;
      cntrIR_ff <= 1'b0;
      done      <= 1'b0;
    end else begin
      cntrIR_ff <= cntrIR;
      line_cnt  <= cnt_nxt;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_vld) begin
            dsrd_hdg <= cmd_hdg;
            target   <= {cmd_sqrs, 1'b0};
            line_cnt <= '0;
            frwrd    <= '0;
            state    <= ALIGN;
          end
        end
        ALIGN: begin
          frwrd <= '0;
          if (heading_rdy && aligned) begin
            if (target == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RAMP_UP;
            end
          end
        end
        RAMP_UP: begin
          // Reaching the line target wins over a ramp step in the same cycle
          if (hit) begin
            state <= RAMP_DN;
          end else if (heading_rdy) begin
            frwrd <= up_val;
            if (up_val == FRWRD_MAX) state <= CRUISE;
          end
        end
        CRUISE: begin
          frwrd <= FRWRD_MAX;
          if (hit) state <= RAMP_DN;
        end
        RAMP_DN: begin
          if (frwrd == '0) begin
            state <= DONE;
            done  <= 1'b1;
          end else if (heading_rdy) begin
            frwrd <= dn_val;
          end
        end
        DONE: begin
          frwrd <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pid_move_sequencer.sv
// Directed self-checking bench for pid_move_sequencer (FAST_SIM=1, step 0x20).
module tb_pid_move_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_vld;
  logic [11:0] cmd_hdg;
  logic [3:0]  cmd_sqrs;
  logic        cmd_rdy;
  logic [11:0] heading;
  logic        heading_rdy;
  logic        cntrIR;
  logic        moving;
  logic [9:0]  frwrd;
  logic [11:0] error;
  logic        err_vld;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pid_move_sequencer #(.FAST_SIM(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_vld(cmd_vld), .cmd_hdg(cmd_hdg), .cmd_sqrs(cmd_sqrs), .cmd_rdy(cmd_rdy),
    .heading(heading), .heading_rdy(heading_rdy), .cntrIR(cntrIR),
    .moving(moving), .frwrd(frwrd), .error(error), .err_vld(err_vld), .done(done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_hdg();
    heading_rdy = 1'b1;
    tick();
    heading_rdy = 1'b0;
  endtask

  task automatic line_edge();
    cntrIR = 1'b1;
    tick();
    cntrIR = 1'b0;
    tick();
  endtask

  task automatic send_cmd(input logic [11:0] h, input logic [3:0] s);
    cmd_vld  = 1'b1;
    cmd_hdg  = h;
    cmd_sqrs = s;
    tick();
    cmd_vld  = 1'b0;
  endtask

  task automatic apply_reset();
    cmd_vld = 1'b0; heading_rdy = 1'b0; cntrIR = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_vld = 1'b0; cmd_hdg = '0; cmd_sqrs = '0;
    heading = 12'h123; heading_rdy = 1'b0; cntrIR = 1'b0;
    #2;
    n_checks++;
    if (frwrd !== 10'h000 || moving !== 1'b0 || done !== 1'b0 || cmd_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state frwrd=%h moving=%b done=%b cmd_rdy=%b exp 000 0 0 1",
               frwrd, moving, done, cmd_rdy);
    end
    n_checks++;
    if (error !== 12'h123) begin
      n_fail++; $display("FAIL reset_error got %h exp 123", error);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    pulse_hdg(); pulse_hdg();
    n_checks++;
    if (moving !== 1'b0 || cmd_rdy !== 1'b1 || frwrd !== 10'h000) begin
      n_fail++;
      $display("FAIL idle_hold moving=%b cmd_rdy=%b frwrd=%h exp 0 1 000", moving, cmd_rdy, frwrd);
    end
  endtask

  task automatic test_wrap_error();
    apply_reset();
    heading = 12'h005;
    send_cmd(12'hFFE, 4'd1);
    n_checks++;
    if (moving !== 1'b1 || cmd_rdy !== 1'b0) begin
      n_fail++; $display("FAIL accept_latency moving=%b cmd_rdy=%b exp 1 0", moving, cmd_rdy);
    end
    n_checks++;
    if (error !== 12'h007 || err_vld !== 1'b0) begin
      n_fail++; $display("FAIL wrap_error error=%h err_vld=%b exp 007 0", error, err_vld);
    end
    heading_rdy = 1'b1;
    #1;
    n_checks++;
    if (err_vld !== 1'b1) begin
      n_fail++; $display("FAIL err_vld_pass got %b exp 1", err_vld);
    end
    tick();
    heading_rdy = 1'b0;
    pulse_hdg();
    n_checks++;
    if (frwrd !== 10'h020) begin
      n_fail++; $display("FAIL wrap_align_exit frwrd=%h exp 020", frwrd);
    end
  endtask

  task automatic test_align_hold();
    apply_reset();
    heading = 12'h400;
    send_cmd(12'h000, 4'd1);
    pulse_hdg(); pulse_hdg(); pulse_hdg();
    n_checks++;
    if (frwrd !== 10'h000 || moving !== 1'b1 || error !== 12'h400) begin
      n_fail++;
      $display("FAIL align_hold frwrd=%h moving=%b error=%h exp 000 1 400", frwrd, moving, error);
    end
    heading = 12'h010;
    pulse_hdg();
    n_checks++;
    if (frwrd !== 10'h000) begin
      n_fail++; $display("FAIL align_exit_frwrd frwrd=%h exp 000", frwrd);
    end
    pulse_hdg();
    n_checks++;
    if (frwrd !== 10'h020) begin
      n_fail++; $display("FAIL align_then_ramp frwrd=%h exp 020", frwrd);
    end
  endtask

  task automatic test_full_move();
    logic [9:0] exp_f;
    apply_reset();
    heading = 12'h000;
    send_cmd(12'h000, 4'd1);
    pulse_hdg();
    for (int i = 1; i <= 26; i++) begin
      pulse_hdg();
      exp_f = (i >= 24) ? 10'h300 : 10'(i * 32);
      n_checks++;
      if (frwrd !== exp_f) begin
        n_fail++; $display("FAIL ramp_up step %0d frwrd=%h exp %h", i, frwrd, exp_f);
      end
    end
    line_edge();
    n_checks++;
    if (frwrd !== 10'h300) begin
      n_fail++; $display("FAIL one_line_hold frwrd=%h exp 300", frwrd);
    end
    line_edge();
    for (int i = 1; i <= 24; i++) begin
      pulse_hdg();
      exp_f = 10'(10'h300 - i * 32);
      n_checks++;
      if (frwrd !== exp_f) begin
        n_fail++; $display("FAIL ramp_dn step %0d frwrd=%h exp %h", i, frwrd, exp_f);
      end
    end
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL done_early got %b exp 0", done);
    end
    tick();
    n_checks++;
    if (done !== 1'b1 || moving !== 1'b1 || cmd_rdy !== 1'b0 || frwrd !== 10'h000) begin
      n_fail++;
      $display("FAIL done_state done=%b moving=%b cmd_rdy=%b frwrd=%h exp 1 1 0 000",
               done, moving, cmd_rdy, frwrd);
    end
    tick();
    n_checks++;
    if (done !== 1'b0 || moving !== 1'b0 || cmd_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL after_done done=%b moving=%b cmd_rdy=%b exp 0 0 1", done, moving, cmd_rdy);
    end
  endtask

  task automatic test_early_stop();
    apply_reset();
    heading = 12'h000;
    send_cmd(12'h000, 4'd1);
    pulse_hdg(); pulse_hdg(); pulse_hdg();
    line_edge(); line_edge();
    n_checks++;
    if (frwrd !== 10'h040) begin
      n_fail++; $display("FAIL early_hold frwrd=%h exp 040", frwrd);
    end
    pulse_hdg();
    n_checks++;
    if (frwrd !== 10'h020) begin
      n_fail++; $display("FAIL early_dn1 frwrd=%h exp 020", frwrd);
    end
    pulse_hdg();
    n_checks++;
    if (frwrd !== 10'h000 || done !== 1'b0) begin
      n_fail++; $display("FAIL early_dn2 frwrd=%h done=%b exp 000 0", frwrd, done);
    end
    tick();
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++; $display("FAIL early_done got %b exp 1", done);
    end
    tick();
    n_checks++;
    if (cmd_rdy !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL early_idle cmd_rdy=%b done=%b exp 1 0", cmd_rdy, done);
    end
  endtask

  task automatic test_zero_sqrs();
    apply_reset();
    heading = 12'h000;
    send_cmd(12'h000, 4'd0);
    pulse_hdg();
    n_checks++;
    if (done !== 1'b1 || frwrd !== 10'h000 || moving !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_sqrs done=%b frwrd=%h moving=%b exp 1 000 1", done, frwrd, moving);
    end
    tick();
    n_checks++;
    if (done !== 1'b0 || cmd_rdy !== 1'b1) begin
      n_fail++; $display("FAIL zero_sqrs_idle done=%b cmd_rdy=%b exp 0 1", done, cmd_rdy);
    end
  endtask

  task automatic test_busy();
    apply_reset();
    heading = 12'h000;
    send_cmd(12'h000, 4'd1);
    pulse_hdg();
    pulse_hdg();
    send_cmd(12'h200, 4'd3);
    n_checks++;
    if (error !== 12'h000 || cmd_rdy !== 1'b0) begin
      n_fail++; $display("FAIL busy_hdg error=%h cmd_rdy=%b exp 000 0", error, cmd_rdy);
    end
    pulse_hdg();
    n_checks++;
    if (frwrd !== 10'h040) begin
      n_fail++; $display("FAIL busy_ramp frwrd=%h exp 040", frwrd);
    end
    heading = 12'h050;
    #1;
    n_checks++;
    if (error !== 12'h050) begin
      n_fail++; $display("FAIL busy_error error=%h exp 050", error);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    heading = 12'h000;
    send_cmd(12'h000, 4'd2);
    pulse_hdg();
    for (int i = 0; i < 26; i++) pulse_hdg();
    n_checks++;
    if (frwrd !== 10'h300) begin
      n_fail++; $display("FAIL cruise_reach frwrd=%h exp 300", frwrd);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (frwrd !== 10'h000 || moving !== 1'b0 || done !== 1'b0 || cmd_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset frwrd=%h moving=%b done=%b cmd_rdy=%b exp 000 0 0 1",
               frwrd, moving, done, cmd_rdy);
    end
    pulse_hdg(); pulse_hdg();
    rst_n = 1'b1;
    pulse_hdg(); pulse_hdg();
    n_checks++;
    if (frwrd !== 10'h000 || moving !== 1'b0 || cmd_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_idle frwrd=%h moving=%b cmd_rdy=%b exp 000 0 1",
               frwrd, moving, cmd_rdy);
    end
  endtask

  initial begin
    test_reset();
    test_wrap_error();
    test_align_hold();
    test_full_move();
    test_early_stop();
    test_zero_sqrs();
    test_busy();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
